// File: rtl/synth_spi_pkg.sv
// Shared definitions for the synthesizer SPI control path.
//  - spi_state_e    : frame sequencer states used by spi_cmd_tx
//  - *_WIDTH_DEF    : default field widths of a control packet
//  - CMD_*          : command opcodes, shared with the command decoder
package synth_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   localparam int CMD_WIDTH_DEF    = 8;
   localparam int DATA_WIDTH_DEF   = 16;
   localparam int PACKET_WIDTH_DEF = CMD_WIDTH_DEF + DATA_WIDTH_DEF;

   localparam logic [7:0] CMD_SET_FREQ  = 8'h01;
   localparam logic [7:0] CMD_SET_AMP   = 8'h03;
   localparam logic [7:0] CMD_WRITE_REG = 8'hA5;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI initiator.
// Ports:
//  sys_clk  in   system clock (rising edge)
//  rst      in   synchronous active-high reset
//  clr_i    in   synchronous clear; restarts the half-period from zero
//  tick_o   out  high in the last cycle of every CLK_DIV-cycle half-period
module spi_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == LAST);
      cnt_d  = cnt_q + 1'b1;
      // Wrap explicitly so non-power-of-two dividers keep an exact period.
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_cmd_tx.sv
// SPI initiator for synthesizer control packets {cmd_word, data_word}, MSB first.
// CPOL=0 / CPHA=0: sclk idles low, mosi changes on falling sclk.
// Ports:
//  sys_clk    in   system clock (rising edge)
//  rst        in   synchronous active-high reset; aborts any frame in flight
//  cmd_word   in   command field of the request
//  data_word  in   data field of the request
//  req_valid  in   request present
//  req_ready  out  pending slot empty; transfer when req_valid && req_ready
//  sclk       out  SPI clock
//  mosi       out  SPI data
//  csb        out  chip select, active low
//  busy       out  high from frame load until the end of the inter-frame gap
//  done       out  one-cycle pulse in the cycle csb returns high
// All outputs come straight from flops so sclk/csb are glitch-free.
module spi_cmd_tx
   import synth_spi_pkg::*;
#(
   parameter int CMD_WIDTH    = CMD_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
   parameter int CLK_DIV      = 4,
   parameter int CS_GAP       = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [CMD_WIDTH-1:0]  cmd_word,
   input  logic [DATA_WIDTH-1:0] data_word,
   input  logic                  req_valid,
   output logic                  req_ready,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  csb,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = $clog2(PACKET_WIDTH + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PACKET_WIDTH - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

   spi_state_e              state_q, state_d;
   logic [PACKET_WIDTH-1:0] slot_q, slot_d;
   logic                    slot_full_q, slot_full_d;
   logic                    ready_q, ready_d;
   logic [PACKET_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic                    csb_q, csb_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    tick;
   logic                    load;
   logic                    accept;

   // The divider restarts on every frame load so SETUP is exactly one half-period.
   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .sys_clk (sys_clk),
      .rst     (rst),
      .clr_i   (load),
      .tick_o  (tick)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      slot_full_d = slot_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      csb_d       = csb_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;

      // ready_q mirrors !slot_full_q, so accept and load can never coincide.
      accept = req_valid && ready_q;
      if (accept) begin
         slot_d      = {cmd_word, data_word};
         slot_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (slot_full_q) begin
               load = 1'b1;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     // Final fall: mosi stays on the LSB through HOLD.
                     bit_cnt_d = '0;
                     state_d   = HOLD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     shift_d   = {shift_q[PACKET_WIDTH-2:0], 1'b0};
                     mosi_d    = shift_q[PACKET_WIDTH-2];
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_d   = GAP;
               csb_d     = 1'b1;
               done_d    = 1'b1;
               mosi_d    = 1'b0;
               gap_cnt_d = '0;
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_cnt_q == LAST_GAP) begin
                  gap_cnt_d = '0;
                  if (slot_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         state_d     = SETUP;
         shift_d     = slot_q;
         mosi_d      = slot_q[PACKET_WIDTH-1];
         sclk_d      = 1'b0;
         csb_d       = 1'b0;
         busy_d      = 1'b1;
         bit_cnt_d   = '0;
         slot_full_d = 1'b0;
      end

      ready_d = !slot_full_d;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         slot_full_q <= 1'b0;
         ready_q     <= 1'b1;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         csb_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         slot_full_q <= slot_full_d;
         ready_q     <= ready_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         csb_q       <= csb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign req_ready = ready_q;
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign csb       = csb_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
